// File: rtl/exc_stage_tracker.sv
// ---------------------------------------------------------------------------
// exc_stage_tracker
//
// One pipeline stage that carries the precise-exception bundle
// (pc, epc, badvaddr, exc_code, is_exc, is_in_ds, is_eret) with a
// valid/allowin handshake. The stage also folds the exception sources it
// detects itself into that bundle, and it drains younger instructions
// after an exception or eret has left the stage, until CP0 raises flush.
//
// Ports
//   clk           clock; every state update happens on posedge
//   reset         synchronous, active-low reset
//   flush         exception/eret commit from CP0; kills the stage content
//   stall         stage-internal stall
//   pre_valid     upstream holds a valid instruction
//   pre_allowin   this stage accepts upstream this cycle
//   post_allowin  downstream accepts
//   valid         stage holds a live instruction
//   pre_*         upstream exception bundle
//   loc_exc_req   local exception requests, index 0 = highest priority
//   loc_exc_code  packed codes, source i at [i*EXC_W +: EXC_W]
//   loc_badvaddr  packed bad addresses, source i at [i*PC_W +: PC_W]
//   pc .. is_eret registered exception bundle
//   en_disable    suppress side effects of this and younger instructions
//   draining      stage is in DRAIN
// ---------------------------------------------------------------------------
module exc_stage_tracker #(
    parameter int PC_W    = 32,
    parameter int EXC_W   = 5,
    parameter int NUM_SRC = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     stall,
    input  logic                     pre_valid,
    output logic                     pre_allowin,
    input  logic                     post_allowin,
    output logic                     valid,
    input  logic [PC_W-1:0]          pre_pc,
    input  logic [PC_W-1:0]          pre_badvaddr,
    input  logic [EXC_W-1:0]         pre_exc_code,
    input  logic                     pre_is_exc,
    input  logic                     pre_is_in_ds,
    input  logic                     pre_is_eret,
    input  logic [NUM_SRC-1:0]       loc_exc_req,
    input  logic [NUM_SRC*EXC_W-1:0] loc_exc_code,
    input  logic [NUM_SRC*PC_W-1:0]  loc_badvaddr,
    output logic [PC_W-1:0]          pc,
    output logic [PC_W-1:0]          epc,
    output logic [PC_W-1:0]          badvaddr,
    output logic [EXC_W-1:0]         exc_code,
    output logic                     is_exc,
    output logic                     is_in_ds,
    output logic                     is_eret,
    output logic                     en_disable,
    output logic                     draining
);

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic             fold;
    logic             ready_go;
    logic             fire_out;
    logic             accept;
    logic [EXC_W-1:0] sel_code;
    logic [PC_W-1:0]  sel_badvaddr;

    // An instruction that already carries an exception ignores local
    // requests, so the earliest-detected exception is the one reported.
    assign fold        = valid && !is_exc && (|loc_exc_req);
    // Folding takes one cycle so downstream always sees the folded bundle.
    assign ready_go    = !stall && !fold;
    assign pre_allowin = !valid || (ready_go && post_allowin);
    assign fire_out    = valid && ready_go && post_allowin;
    assign accept      = pre_valid && pre_allowin;

    assign draining    = (state == DRAIN);
    assign en_disable  = (valid && (is_exc || is_eret)) || draining || fold;

    // Walk from the lowest priority upwards so the lowest asserted index
    // is the last writer and wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise paths that skip an assignment infer a latch.
        sel_code     = '0;
        sel_badvaddr = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (loc_exc_req[i]) begin
                sel_code     = loc_exc_code[i*EXC_W +: EXC_W];
                sel_badvaddr = loc_badvaddr[i*PC_W +: PC_W];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block order.
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. Flush always returns to RUN, even when it lands on
    // the same cycle as the exception leaving the stage.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = RUN;
        end else if (state == RUN && fire_out && (is_exc || is_eret)) begin
            state_next = DRAIN;
        end
    end

    // Valid flag and exception bundle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid    <= 1'b0;
            pc       <= '0;
            epc      <= '0;
            badvaddr <= '0;
            exc_code <= '0;
            is_exc   <= 1'b0;
            is_in_ds <= 1'b0;
            is_eret  <= 1'b0;
        end else if (flush) begin
            // Payload is left as is; only the instruction is killed.
            valid <= 1'b0;
        end else if (fold) begin
            exc_code <= sel_code;
            badvaddr <= sel_badvaddr;
            is_exc   <= 1'b1;
            is_eret  <= 1'b0;
        end else if (accept) begin
            if (state == RUN) begin
                valid    <= 1'b1;
                pc       <= pre_pc;
                // A delay-slot instruction reports the branch as EPC; the
                // subtraction wraps modulo 2^PC_W.
                epc      <= pre_is_in_ds ? (pre_pc - PC_W'(4)) : pre_pc;
                badvaddr <= pre_badvaddr;
                exc_code <= pre_exc_code;
                is_exc   <= pre_is_exc;
                is_in_ds <= pre_is_in_ds;
                is_eret  <= pre_is_eret;
            end else begin
                // Younger instruction swallowed while draining.
                valid <= 1'b0;
            end
        end else if (fire_out) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exc_stage_tracker.sv
// ---------------------------------------------------------------------------
// tb_exc_stage_tracker
//
// Directed bench for exc_stage_tracker. The driver pushes the bundle each
// instruction should leave the stage with into a queue; a monitor pops and
// compares whenever the stage hands an instruction downstream. Control
// outputs (valid, pre_allowin, en_disable, draining) are checked inline.
// ---------------------------------------------------------------------------
module tb_exc_stage_tracker;

    localparam int PC_W    = 32;
    localparam int EXC_W   = 5;
    localparam int NUM_SRC = 2;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic [PC_W-1:0]  epc;
        logic [PC_W-1:0]  badvaddr;
        logic [EXC_W-1:0] code;
        logic             exc;
        logic             ds;
        logic             eret;
    } bundle_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     flush;
    logic                     stall;
    logic                     pre_valid;
    logic                     pre_allowin;
    logic                     post_allowin;
    logic                     valid;
    logic [PC_W-1:0]          pre_pc;
    logic [PC_W-1:0]          pre_badvaddr;
    logic [EXC_W-1:0]         pre_exc_code;
    logic                     pre_is_exc;
    logic                     pre_is_in_ds;
    logic                     pre_is_eret;
    logic [NUM_SRC-1:0]       loc_exc_req;
    logic [NUM_SRC*EXC_W-1:0] loc_exc_code;
    logic [NUM_SRC*PC_W-1:0]  loc_badvaddr;
    logic [PC_W-1:0]          pc;
    logic [PC_W-1:0]          epc;
    logic [PC_W-1:0]          badvaddr;
    logic [EXC_W-1:0]         exc_code;
    logic                     is_exc;
    logic                     is_in_ds;
    logic                     is_eret;
    logic                     en_disable;
    logic                     draining;

    int      checks   = 0;
    int      failures = 0;
    bundle_t exp_q[$];

    exc_stage_tracker #(
        .PC_W    (PC_W),
        .EXC_W   (EXC_W),
        .NUM_SRC (NUM_SRC)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .stall        (stall),
        .pre_valid    (pre_valid),
        .pre_allowin  (pre_allowin),
        .post_allowin (post_allowin),
        .valid        (valid),
        .pre_pc       (pre_pc),
        .pre_badvaddr (pre_badvaddr),
        .pre_exc_code (pre_exc_code),
        .pre_is_exc   (pre_is_exc),
        .pre_is_in_ds (pre_is_in_ds),
        .pre_is_eret  (pre_is_eret),
        .loc_exc_req  (loc_exc_req),
        .loc_exc_code (loc_exc_code),
        .loc_badvaddr (loc_badvaddr),
        .pc           (pc),
        .epc          (epc),
        .badvaddr     (badvaddr),
        .exc_code     (exc_code),
        .is_exc       (is_exc),
        .is_in_ds     (is_in_ds),
        .is_eret      (is_eret),
        .en_disable   (en_disable),
        .draining     (draining)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_bundle(input logic [31:0] e_pc, input logic [31:0] e_epc,
                                 input logic [31:0] e_bad, input logic [4:0] e_code,
                                 input logic e_exc, input logic e_ds, input logic e_eret);
        bundle_t b;
        b.pc       = e_pc;
        b.epc      = e_epc;
        b.badvaddr = e_bad;
        b.code     = e_code;
        b.exc      = e_exc;
        b.ds       = e_ds;
        b.eret     = e_eret;
        exp_q.push_back(b);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: with valid=1, pre_allowin equals fire_out, so valid &&
    // pre_allowin marks an instruction leaving the stage.
    initial begin
        bundle_t b;
        forever begin
            @(negedge clk);
            if (valid === 1'b1 && pre_allowin === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fire_pc", pc, 32'hDEAD_BEEF);
                end else begin
                    b = exp_q.pop_front();
                    check("out_pc",       pc,                b.pc);
                    check("out_epc",      epc,               b.epc);
                    check("out_badvaddr", badvaddr,          b.badvaddr);
                    check("out_exc_code", 32'(exc_code),     32'(b.code));
                    check("out_is_exc",   32'(is_exc),       32'(b.exc));
                    check("out_is_in_ds", 32'(is_in_ds),     32'(b.ds));
                    check("out_is_eret",  32'(is_eret),      32'(b.eret));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset        = 1'b0;
        flush        = 1'b0;
        stall        = 1'b0;
        pre_valid    = 1'b0;
        post_allowin = 1'b1;
        pre_pc       = '0;
        pre_badvaddr = '0;
        pre_exc_code = '0;
        pre_is_exc   = 1'b0;
        pre_is_in_ds = 1'b0;
        pre_is_eret  = 1'b0;
        loc_exc_req  = '0;
        loc_exc_code = {5'h05, 5'h04};
        loc_badvaddr = {32'h0000_2000, 32'h0000_1000};

        // Reset state.
        cyc();
        cyc();
        mid();
        check("rst_valid",       32'(valid),       0);
        check("rst_draining",    32'(draining),    0);
        check("rst_en_disable",  32'(en_disable),  0);
        check("rst_pc",          pc,               0);
        check("rst_epc",         epc,              0);
        check("rst_exc_code",    32'(exc_code),    0);
        check("rst_pre_allowin", 32'(pre_allowin), 1);
        cyc();
        reset = 1'b1;

        // Delay-slot instruction passes straight through.
        pre_valid    = 1'b1;
        pre_pc       = 32'hBFC0_0010;
        pre_is_in_ds = 1'b1;
        expect_bundle(32'hBFC0_0010, 32'hBFC0_000C, 0, 5'h00, 0, 1, 0);
        mid();
        check("t1_pre_allowin", 32'(pre_allowin), 1);
        cyc();
        pre_valid    = 1'b0;
        pre_is_in_ds = 1'b0;
        mid();
        check("t1_valid",      32'(valid),      1);
        check("t1_pc",         pc,              32'hBFC0_0010);
        check("t1_epc",        epc,             32'hBFC0_000C);
        check("t1_en_disable", 32'(en_disable), 0);
        cyc();
        mid();
        check("t1_valid_drop", 32'(valid), 0);

        // Local fold: both sources asserted, source 0 wins.
        post_allowin = 1'b0;
        pre_valid    = 1'b1;
        pre_pc       = 32'h0000_0100;
        expect_bundle(32'h0000_0100, 32'h0000_0100, 32'h0000_1000, 5'h04, 1, 0, 0);
        cyc();
        pre_valid    = 1'b0;
        post_allowin = 1'b1;
        loc_exc_req  = 2'b11;
        mid();
        check("t2_fold_pre_allowin", 32'(pre_allowin), 0);
        check("t2_fold_en_disable",  32'(en_disable),  1);
        check("t2_fold_is_exc_pre",  32'(is_exc),      0);
        cyc();
        mid();
        check("t2_exc_code",    32'(exc_code),    32'h04);
        check("t2_badvaddr",    badvaddr,         32'h0000_1000);
        check("t2_is_exc",      32'(is_exc),      1);
        check("t2_sticky_fire", 32'(pre_allowin), 1);
        cyc();
        loc_exc_req = '0;
        mid();
        check("t2_draining", 32'(draining),   1);
        check("t2_valid",    32'(valid),      0);
        check("t2_en_dis",   32'(en_disable), 1);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        mid();
        check("t2_flush_run", 32'(draining), 0);

        // Upstream exception beats a later local request; no fold stall.
        // The exception fires on the same cycle as a flush -> stays in RUN.
        post_allowin = 1'b0;
        pre_valid    = 1'b1;
        pre_pc       = 32'h0000_0200;
        pre_badvaddr = 32'h0000_0300;
        pre_is_exc   = 1'b1;
        pre_exc_code = 5'h0A;
        expect_bundle(32'h0000_0200, 32'h0000_0200, 32'h0000_0300, 5'h0A, 1, 0, 0);
        cyc();
        pre_valid    = 1'b0;
        pre_is_exc   = 1'b0;
        pre_exc_code = '0;
        pre_badvaddr = '0;
        post_allowin = 1'b1;
        loc_exc_req  = 2'b01;
        flush        = 1'b1;
        mid();
        check("t3_no_fold_stall", 32'(pre_allowin), 1);
        check("t3_exc_code_kept", 32'(exc_code),    32'h0A);
        check("t3_en_disable",    32'(en_disable),  1);
        cyc();
        flush       = 1'b0;
        loc_exc_req = '0;
        mid();
        check("t3_flush_fire_run", 32'(draining), 0);
        check("t3_valid",          32'(valid),    0);

        // Eret leaves -> DRAIN; three younger instructions are swallowed.
        pre_valid   = 1'b1;
        pre_pc      = 32'h0000_0400;
        pre_is_eret = 1'b1;
        expect_bundle(32'h0000_0400, 32'h0000_0400, 0, 5'h00, 0, 0, 1);
        cyc();
        pre_valid   = 1'b0;
        pre_is_eret = 1'b0;
        mid();
        check("t4_eret_en_disable", 32'(en_disable), 1);
        cyc();
        mid();
        check("t4_draining", 32'(draining), 1);
        pre_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pre_pc = 32'h0000_0500 + 32'(4 * i);
            #1;
            check("t4_drain_accept", 32'(pre_allowin), 1);
            cyc();
            mid();
            check("t4_drain_valid", 32'(valid),      0);
            check("t4_drain_pc",    pc,              32'h0000_0400);
            check("t4_drain_endis", 32'(en_disable), 1);
        end
        pre_valid = 1'b0;
        flush     = 1'b1;
        cyc();
        flush = 1'b0;
        mid();
        check("t4_run_again",   32'(draining),   0);
        check("t4_endis_clear", 32'(en_disable), 0);
        pre_valid = 1'b1;
        pre_pc    = 32'h0000_0600;
        expect_bundle(32'h0000_0600, 32'h0000_0600, 0, 5'h00, 0, 0, 0);
        cyc();
        pre_valid = 1'b0;
        mid();
        check("t4_capture_valid", 32'(valid), 1);
        check("t4_capture_pc",    pc,         32'h0000_0600);
        cyc();
        mid();
        check("t4_capture_drop", 32'(valid), 0);

        // Flush beats an accept: nothing is loaded.
        post_allowin = 1'b0;
        pre_valid    = 1'b1;
        pre_pc       = 32'h0000_0700;
        flush        = 1'b1;
        cyc();
        flush        = 1'b0;
        pre_valid    = 1'b0;
        post_allowin = 1'b1;
        mid();
        check("t5_flush_valid", 32'(valid), 0);
        check("t5_flush_pc",    pc,         32'h0000_0600);

        // Stall holds everything; pc=0 in a delay slot wraps epc.
        pre_valid    = 1'b1;
        pre_pc       = 32'h0000_0000;
        pre_is_in_ds = 1'b1;
        expect_bundle(32'h0000_0000, 32'hFFFF_FFFC, 0, 5'h00, 0, 1, 0);
        cyc();
        pre_valid    = 1'b0;
        pre_is_in_ds = 1'b0;
        stall        = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("t6_stall_allowin", 32'(pre_allowin), 0);
            check("t6_stall_valid",   32'(valid),       1);
            check("t6_stall_epc",     epc,              32'hFFFF_FFFC);
            cyc();
        end
        stall = 1'b0;
        cyc();
        mid();
        check("t6_after_fire", 32'(valid), 0);

        // Reset in the middle of DRAIN.
        pre_valid   = 1'b1;
        pre_pc      = 32'h0000_0900;
        pre_is_eret = 1'b1;
        expect_bundle(32'h0000_0900, 32'h0000_0900, 0, 5'h00, 0, 0, 1);
        cyc();
        pre_valid   = 1'b0;
        pre_is_eret = 1'b0;
        cyc();
        mid();
        check("t7_draining", 32'(draining), 1);
        check("t7_pc",       pc,            32'h0000_0900);
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        mid();
        check("t7_rst_draining", 32'(draining),   0);
        check("t7_rst_valid",    32'(valid),      0);
        check("t7_rst_pc",       pc,              0);
        check("t7_rst_endis",    32'(en_disable), 0);

        cyc();
        cyc();
        check("scoreboard_left", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/exc_stage_tracker.md
Name: exc_stage_tracker

Overview:
- Parametrised pipeline-stage register for precise exceptions in the MIPS core.
- Carries the exception bundle (pc, epc, badvaddr, excCode, is_exc, is_in_ds, is_eret) through one stage with a valid/allowin handshake.
- Folds NUM_SRC local exception sources into that bundle by fixed priority.
- Drains younger instructions after an exception or eret has left the stage, until CP0 issues flush.

Parameters:
- PC_W, 32, width of pc/epc/badvaddr.
- EXC_W, 5, excCode width.
- NUM_SRC, 2, local exception sources detected in this stage (1..8); index 0 is highest priority.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  exception/eret commit from CP0; kills stage content.
- stall  in  1  stage-internal stall.
- pre_valid  in  1  upstream holds a valid instruction.
- pre_allowin  out  1  this stage accepts upstream this cycle.
- post_allowin  in  1  downstream accepts.
- valid  out  1  stage holds a live instruction.
- pre_pc, pre_badvaddr  in  PC_W each  upstream bundle.
- pre_exc_code  in  EXC_W  upstream bundle.
- pre_is_exc, pre_is_in_ds, pre_is_eret  in  1 each  upstream bundle.
- loc_exc_req  in  NUM_SRC  local exception requests for the held instruction.
- loc_exc_code  in  NUM_SRC*EXC_W  packed, source i at [i*EXC_W +: EXC_W].
- loc_badvaddr  in  NUM_SRC*PC_W  packed likewise.
- pc, epc, badvaddr  out  PC_W each  registered bundle.
- exc_code  out  EXC_W  registered bundle.
- is_exc, is_in_ds, is_eret  out  1 each  registered bundle.
- en_disable  out  1  suppress side effects (stores, HI/LO, regfile write) of this and younger instructions.
- draining  out  1  state is DRAIN.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset==0 at posedge):
  - valid=0, state RUN.
  - pc/epc/badvaddr/exc_code/flags=0.
  - en_disable=0, draining=0.
- fold = valid && !is_exc && |loc_exc_req.
- ready_go = !stall && !fold. A fold costs exactly one cycle, so downstream always sees the folded bundle.
- pre_allowin = !valid || (ready_go && post_allowin).
- fire_out = valid && ready_go && post_allowin.
- Priority at each posedge (highest first):
  - reset
  - flush
  - fold
  - accept (pre_valid && pre_allowin)
  - fire_out only
- flush: valid<=0, state<=RUN. Payload is unchanged. Flush wins over stall, fold and pre_valid in the same cycle.
- fold, lowest asserted index k wins:
  - exc_code<=code[k], badvaddr<=badvaddr[k], is_exc<=1, is_eret<=0 (exception beats eret).
  - valid is held. No accept occurs that cycle, because pre_allowin=0.
- Existing is_exc=1 always beats local requests: later local requests are ignored, and the upstream-detected exception is kept.
- accept in RUN:
  - Load the pre_* bundle and set valid<=1.
  - epc<=pre_is_in_ds ? pre_pc-4 : pre_pc, modulo 2^PC_W (pc=0 with ds gives all-ones-minus-3).
- accept in DRAIN: the instruction is consumed, but valid<=0 and the payload is not loaded.
- fire_out with no accept: valid<=0.
- State machine:
  - RUN -> DRAIN on fire_out with (is_exc || is_eret).
  - DRAIN -> RUN on flush only.
  - A flush on the same cycle as fire_out: flush wins, next state RUN.
- en_disable = (valid && (is_exc || is_eret)) || state==DRAIN || fold. This is combinational from registers and local requests.
- Back-to-back accepts at full throughput when stall=0 and post_allowin=1: 1 instruction/cycle, 1-cycle latency.
- Downstream stall: bundle and valid are held unchanged. Local requests arriving during the hold still fold; folding is sticky once is_exc=1.
- Reset mid-DRAIN or mid-hold returns to reset values next cycle.

Test Plan:
- Reset then pre_valid=1, pre_pc=0xBFC00010, pre_is_in_ds=1, no exc, post_allowin=1 -> next cycle valid=1, pc=0xBFC00010, epc=0xBFC0000C, en_disable=0; valid drops one cycle after pre_valid deasserts.
- Held instr, loc_exc_req=2'b11, codes {0x04, 0x05}, badvaddrs {0x1000, 0x2000} -> that cycle pre_allowin=0, en_disable=1; next cycle exc_code=0x04, badvaddr=0x1000, is_exc=1; fires following cycle.
- Upstream pre_is_exc=1, exc_code=0x0A, then loc_exc_req=1 code 0x04 -> exc_code stays 0x0A, no fold stall (ready_go=1).
- Eret instr fires -> draining=1; next 3 upstream instrs accepted with valid staying 0 and en_disable=1; flush -> RUN, next instr captured normally.
- flush asserted with pre_valid=1 and post_allowin=0 -> valid=0 next cycle, bundle not loaded; flush coincident with exc fire_out -> state RUN, not DRAIN.
- stall=1 for 4 cycles with valid instr -> outputs stable, pre_allowin=0; reset asserted in DRAIN -> valid=0, draining=0 next cycle.
